// File: rtl/rng_arbiter_if.sv
// Request/response bundle between requesters and the shared random source.
// The master side drives requests, bounds and seeding; the slave side
// (the arbiter) returns the acknowledge, the result and its busy flag.
interface rng_arbiter_if #(
    parameter int unsigned N_REQ = 4
);
    logic                   seed_load;
    logic [8:0]             seed;
    logic [N_REQ-1:0]       req;
    logic [9*N_REQ-1:0]     bound;
    logic [N_REQ-1:0]       ack;
    logic [8:0]             rnd;
    logic                   busy;

    modport master (
        output seed_load, seed, req, bound,
        input  ack, rnd, busy
    );

    modport slave (
        input  seed_load, seed, req, bound,
        output ack, rnd, busy
    );
endinterface

// File: rtl/rng_arbiter.sv
// Round-robin arbiter sharing one 9-bit Galois LFSR among N_REQ requesters.
// Each granted request gets a value in [0, bound) by masked rejection
// sampling, falling back to a single subtraction after MAX_TRY attempts.
module rng_arbiter #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned MAX_TRY = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    rng_arbiter_if.slave    bus
);

    localparam int unsigned PW = (N_REQ > 1)   ? $clog2(N_REQ)   : 1;
    localparam int unsigned TW = (MAX_TRY > 1) ? $clog2(MAX_TRY) : 1;
    localparam logic [8:0]  LFSR_INIT = 9'h1BD;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAW,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [8:0]         r_lfsr;
    logic [PW-1:0]      r_ptr;
    logic [PW-1:0]      r_win;
    logic [8:0]         r_bound;
    logic [TW-1:0]      r_try;
    logic [N_REQ-1:0]   r_ack;
    logic [8:0]         r_rnd;
    logic               r_busy;

    logic [8:0]         w_lfsr_next;
    logic               w_any;
    logic [PW-1:0]      w_win;
    logic [8:0]         w_bound_sel;
    logic [8:0]         w_bm1;
    logic [8:0]         w_s1;
    logic [8:0]         w_s2;
    logic [8:0]         w_s4;
    logic [8:0]         w_mask;
    logic [8:0]         w_cand;
    logic               w_draw_done;
    logic [8:0]         w_draw_rnd;

    // Galois step of the shared random source
    always_comb begin
        w_lfsr_next = {r_lfsr[0], r_lfsr[8], r_lfsr[7:5],
                       r_lfsr[4] ^ r_lfsr[0],
                       r_lfsr[3] ^ r_lfsr[0],
                       r_lfsr[2] ^ r_lfsr[0],
                       r_lfsr[1]};
    end

    // LFSR advances every edge; a seed load overrides the step, zero seed is replaced
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= LFSR_INIT;
        end else if (bus.seed_load) begin
            r_lfsr <= (bus.seed == '0) ? LFSR_INIT : bus.seed;
        end else begin
            r_lfsr <= w_lfsr_next;
        end
    end

    // Round-robin winner: scan from r_ptr upward, the closest set request wins
    always_comb begin
        logic [PW-1:0] v_idx;
        v_idx = '0;
        w_win = '0;
        w_any = |bus.req;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            // walk offsets from farthest to nearest so the nearest assignment sticks
            v_idx = PW'((32'(r_ptr) + (N_REQ - 1 - k)) % N_REQ);
            if (bus.req[v_idx]) begin
                w_win = v_idx;
            end
        end
    end

    // Bound slice of the current winner
    always_comb begin
        w_bound_sel = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (w_win == PW'(k)) begin
                w_bound_sel = bus.bound[9*k +: 9];
            end
        end
    end

    // Candidate draw: mask is bound-1 smeared right to the next 2^k-1
    always_comb begin
        w_bm1  = r_bound - 9'd1;
        w_s1   = w_bm1 | (w_bm1 >> 1);
        w_s2   = w_s1  | (w_s1  >> 2);
        w_s4   = w_s2  | (w_s2  >> 4);
        w_mask = w_s4  | (w_s4  >> 8);
        w_cand = r_lfsr & w_mask;

        w_draw_done = 1'b0;
        w_draw_rnd  = '0;
        if (r_bound <= 9'd1) begin
            w_draw_done = 1'b1;
            w_draw_rnd  = '0;
        end else if (w_cand < r_bound) begin
            w_draw_done = 1'b1;
            w_draw_rnd  = w_cand;
        end else if (r_try == TW'(MAX_TRY - 1)) begin
            // mask < 2*bound, so this lands inside [0, bound)
            w_draw_done = 1'b1;
            w_draw_rnd  = w_cand - r_bound;
        end
    end

    // Arbitration FSM with registered ack/rnd/busy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_win   <= '0;
            r_bound <= '0;
            r_try   <= '0;
            r_ack   <= '0;
            r_rnd   <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_ack <= '0;
                    if (w_any) begin
                        r_win   <= w_win;
                        r_bound <= w_bound_sel;
                        r_try   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_DRAW;
                    end
                end
                S_DRAW: begin
                    if (w_draw_done) begin
                        r_rnd        <= w_draw_rnd;
                        r_ack        <= '0;
                        r_ack[r_win] <= 1'b1;
                        r_state      <= S_DONE;
                    end else begin
                        r_try <= r_try + 1'b1;
                    end
                end
                S_DONE: begin
                    r_ack   <= '0;
                    r_busy  <= 1'b0;
                    r_ptr   <= (r_win == PW'(N_REQ - 1)) ? '0 : r_win + 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_ack   <= '0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.ack  = r_ack;
    assign bus.rnd  = r_rnd;
    assign bus.busy = r_busy;

endmodule

// File: tb/tb_rng_arbiter.sv
// Directed checks of the shared random arbiter followed by a randomized
// request stream with per-grant bound, one-hot and fairness checks.
module tb_rng_arbiter;

    localparam int unsigned N     = 4;
    localparam int unsigned MT    = 4;
    localparam int unsigned TOTAL = 3000;
    localparam int unsigned BUDGET = 60000;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    rng_arbiter_if #(.N_REQ(N)) bus();

    rng_arbiter #(.N_REQ(N), .MAX_TRY(MT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int unsigned checks   = 0;
    int unsigned failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits up to max_cyc falling edges for any ack; lat stays 0 if no ack arrives
    task automatic wait_ack(input int unsigned max_cyc, output int unsigned lat,
                            output logic [N-1:0] a);
        lat = 0;
        a   = '0;
        for (int unsigned c = 1; c <= max_cyc; c++) begin
            @(negedge clk);
            if (bus.ack != '0) begin
                lat = c;
                a   = bus.ack;
                break;
            end
        end
    endtask

    initial begin
        int unsigned  lat;
        logic [N-1:0] a;
        logic [8:0]   bnd [N];
        int unsigned  waitg [N];
        int unsigned  issued;
        int unsigned  served;
        int unsigned  cyc;

        rst_n         = 1'b0;
        bus.seed_load = 1'b0;
        bus.seed      = '0;
        bus.req       = '0;
        bus.bound     = '0;

        // reset values and LFSR sequence
        @(negedge clk);
        @(negedge clk);
        chk("rst_ack",  32'(bus.ack),  32'h0);
        chk("rst_rnd",  32'(bus.rnd),  32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_lfsr", 32'(dut.r_lfsr), 32'h1BD);
        rst_n = 1'b1;
        #1;
        chk("lfsr_after_release", 32'(dut.r_lfsr), 32'h1BD);
        @(negedge clk);
        chk("lfsr_step1", 32'(dut.r_lfsr), 32'h1D0);
        @(negedge clk);
        chk("lfsr_step2", 32'(dut.r_lfsr), 32'h0E8);
        bus.seed_load = 1'b1;
        bus.seed      = 9'h000;
        @(negedge clk);
        chk("seed_zero", 32'(dut.r_lfsr), 32'h1BD);
        bus.seed = 9'h0A5;
        @(negedge clk);
        chk("seed_0a5", 32'(dut.r_lfsr), 32'h0A5);
        bus.seed_load = 1'b0;

        // first draw after reset: lfsr 0x1D0, mask 0xFF -> 208
        rst_n = 1'b0;
        @(negedge clk);
        rst_n          = 1'b1;
        bus.bound[8:0] = 9'd256;
        bus.req        = 4'b0001;
        wait_ack(8, lat, a);
        chk("b256_lat", 32'(lat), 32'd2);
        chk("b256_ack", 32'(a),   32'b0001);
        chk("b256_rnd", 32'(bus.rnd), 32'd208);
        bus.req = '0;
        @(negedge clk);
        chk("b256_ack_pulse", 32'(bus.ack),  32'h0);
        chk("b256_idle_busy", 32'(bus.busy), 32'h0);
        chk("b256_rnd_held",  32'(bus.rnd),  32'd208);

        // all requesting with bound 1: round-robin order, 3 cycles per grant
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) bus.bound[9*i +: 9] = 9'd1;
        bus.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_ack(10, lat, a);
            chk("rr_lat", 32'(lat), (k == 0) ? 32'd2 : 32'd3);
            chk("rr_ack", 32'(a),   32'(1) << (k % N));
            chk("rr_rnd", 32'(bus.rnd), 32'h0);
        end
        bus.req = '0;
        @(negedge clk);
        chk("rr_ack_pulse", 32'(bus.ack), 32'h0);

        // bound 5 with lfsr pinned at 7: every try rejects, fallback 7-5=2
        bus.seed_load    = 1'b1;
        bus.seed         = 9'd7;
        bus.bound[17:9]  = 9'd5;
        bus.req          = 4'b0010;
        wait_ack(12, lat, a);
        chk("fallback_lat", 32'(lat), 32'(MT + 1));
        chk("fallback_ack", 32'(a),   32'b0010);
        chk("fallback_rnd", 32'(bus.rnd), 32'd2);
        bus.req       = '0;
        bus.seed_load = 1'b0;
        @(negedge clk);

        // bound 0 returns 0 without drawing
        bus.bound[26:18] = 9'd0;
        bus.req          = 4'b0100;
        wait_ack(8, lat, a);
        chk("b0_lat", 32'(lat), 32'd2);
        chk("b0_ack", 32'(a),   32'b0100);
        chk("b0_rnd", 32'(bus.rnd), 32'd0);
        bus.req = '0;
        @(negedge clk);

        // bound 511 uses the full 9-bit mask
        bus.seed_load     = 1'b1;
        bus.seed          = 9'h123;
        bus.bound[35:27]  = 9'd511;
        bus.req           = 4'b1000;
        wait_ack(8, lat, a);
        chk("b511_lat", 32'(lat), 32'd2);
        chk("b511_ack", 32'(a),   32'b1000);
        chk("b511_rnd", 32'(bus.rnd), 32'h123);
        bus.req = '0;
        @(negedge clk);

        // reset in the middle of a draw aborts it
        bus.seed         = 9'd7;
        bus.bound[8:0]   = 9'd5;
        bus.req          = 4'b0001;
        @(negedge clk);
        @(negedge clk);
        chk("abort_busy_before", 32'(bus.busy), 32'h1);
        chk("abort_ack_before",  32'(bus.ack),  32'h0);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(bus.busy), 32'h0);
        chk("abort_rnd",  32'(bus.rnd),  32'h0);
        chk("abort_ack",  32'(bus.ack),  32'h0);
        chk("abort_lfsr", 32'(dut.r_lfsr), 32'h1BD);
        chk("abort_ptr",  32'(dut.r_ptr),  32'h0);
        bus.req       = '0;
        bus.seed_load = 1'b0;
        @(negedge clk);
        chk("abort_ack_in_rst", 32'(bus.ack), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_ack_after", 32'(bus.ack),  32'h0);
        chk("abort_idle",      32'(bus.busy), 32'h0);
        chk("abort_lfsr_step", 32'(dut.r_lfsr), 32'h1D0);
        chk("abort_ptr_after", 32'(dut.r_ptr),  32'h0);

        // randomized requesters honouring the handshake
        issued = 0;
        served = 0;
        cyc    = 0;
        for (int i = 0; i < N; i++) begin
            bnd[i]   = '0;
            waitg[i] = 0;
        end
        while (served < TOTAL && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
            bus.seed_load = ($urandom_range(0, 15) == 0);
            bus.seed      = 9'($urandom_range(0, 511));
            if (bus.ack != '0) begin
                chk("rand_onehot", 32'($onehot(bus.ack)), 32'h1);
                for (int i = 0; i < N; i++) begin
                    if (bus.ack[i]) begin
                        chk("rand_ack_pending", 32'(bus.req[i]), 32'h1);
                        chk("rand_rnd_lt_bound", 32'(bus.rnd < bnd[i]), 32'h1);
                        chk("rand_no_starve", 32'(waitg[i] <= N - 1), 32'h1);
                        bus.req[i] = 1'b0;
                        served++;
                    end else if (bus.req[i]) begin
                        waitg[i]++;
                    end
                end
            end else begin
                for (int j = 0; j < N; j++) begin
                    if (!bus.req[j] && issued < TOTAL && $urandom_range(0, 2) == 0) begin
                        bnd[j]               = 9'($urandom_range(2, 511));
                        bus.bound[9*j +: 9]  = bnd[j];
                        bus.req[j]           = 1'b1;
                        waitg[j]             = 0;
                        issued++;
                    end
                end
            end
        end
        bus.seed_load = 1'b0;
        chk("rand_all_served", served, TOTAL);
        chk("rand_none_pending", 32'(bus.req), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
